hit_judge: RTL and testbench

- Sits directly downstream of the note scroller (shift_load). Consumes its judge-row flags, running combo and song-end pulse, and returns the `delete` pulse that clears a hit note.
- Synchronises and debounces the red and blue player buttons.
- Decides hit, wrong press and miss for each note at the judge row.
- Accumulates score, max combo and hit/miss/wrong counters for the result screen.

---
 rtl/hit_judge_if.sv | 22 ++
 rtl/hit_judge.sv | 162 ++++++++++++++++
 tb/tb_hit_judge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_judge_if.sv
// Link between the note scroller and the hit judge.
// Ports: note_R_judge/note_B_judge (note at judge row), combo (running combo),
//        finish (song end), delete (judge -> scroller, clear the judged note).
interface hit_judge_if;
  logic       note_R_judge;
  logic       note_B_judge;
  logic [7:0] combo;
  logic       finish;
  logic       delete;

  // Scroller side: drives notes/combo/finish, receives delete.
  modport master (
    output note_R_judge, note_B_judge, combo, finish,
    input  delete
  );

  // Judge side.
  modport slave (
    input  note_R_judge, note_B_judge, combo, finish,
    output delete
  );
endinterface

// File: rtl/hit_judge.sv
// Hit judge: debounces red/blue buttons, scores hits, wrong presses and misses at the judge row.
// Latency: delete rises 1 cycle after the debounced press pulse; buttons add 2 sync + DEBOUNCE_CYCLES cycles.
// Backpressure: none; upstream must clear the judge-row note on the cycle after delete.
// Ports: clk, rst (async, active high); red/blue_button raw inputs; yellow_button leaves RESULT;
//        song starts play; link = scroller interface; score/max_combo/hit/miss/wrong counters;
//        result_valid high while in RESULT.
module hit_judge #(
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int HIT_POINTS        = 10,
  parameter int COMBO_BONUS_SHIFT = 3,
  parameter int SCORE_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               red_button,
  input  logic               blue_button,
  input  logic               yellow_button,
  input  logic [1:0]         song,
  hit_judge_if.slave         link,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         max_combo,
  output logic [7:0]         hit_count,
  output logic [7:0]         miss_count,
  output logic [7:0]         wrong_count,
  output logic               result_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state, next_state;

  // Button path; bit 0 is red, bit 1 is blue.
  logic [1:0]       raw, sync1, sync2, deb, deb_d, press;
  logic [CNT_W-1:0] db_cnt [2];

  assign raw = {blue_button, red_button};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_d     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive cycles the synced level disagrees with the debounced one.
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (song != 2'd0)  next_state = PLAY;
      PLAY:    if (link.finish)   next_state = RESULT;
      RESULT:  if (yellow_button) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Judging
  logic             del_q, del_d;
  logic [1:0]       note_q;
  logic             lock, hit, miss, start;
  logic [1:0]       wrong_inc;
  logic [SCORE_W:0] score_sum;
  logic [8:0]       wrong_sum;

  assign link.delete = del_q;
  // Lockout spans the delete cycle and the one after, while upstream clears the note.
  assign lock  = del_q | del_d;
  assign start = (state == IDLE) && (song != 2'd0);

  always_comb begin
    hit       = 1'b0;
    wrong_inc = 2'd0;
    // finish wins over any press in the same cycle.
    if (state == PLAY && !link.finish) begin
      if (lock) begin
        wrong_inc = {1'b0, press[0]} + {1'b0, press[1]};
      end else if (press[0] && link.note_R_judge) begin
        hit       = 1'b1;
        wrong_inc = {1'b0, press[1]};
      end else if (press[1] && link.note_B_judge) begin
        hit       = 1'b1;
        wrong_inc = {1'b0, press[0]};
      end else begin
        wrong_inc = {1'b0, press[0]} + {1'b0, press[1]};
      end
    end
  end

  // A note leaving the judge row without having been deleted is a miss; one per cycle.
  assign miss = (state == PLAY) && !del_d &&
                ((note_q[0] && !link.note_R_judge) || (note_q[1] && !link.note_B_judge));

  assign score_sum = {1'b0, score} + (SCORE_W+1)'(HIT_POINTS)
                   + (SCORE_W+1)'(link.combo >> COMBO_BONUS_SHIFT);
  assign wrong_sum = {1'b0, wrong_count} + 9'(wrong_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      del_q        <= 1'b0;
      del_d        <= 1'b0;
      note_q       <= '0;
      result_valid <= 1'b0;
      score        <= '0;
      max_combo    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      wrong_count  <= '0;
    end else begin
      del_q        <= hit;
      del_d        <= del_q;
      note_q       <= {link.note_B_judge, link.note_R_judge};
      result_valid <= (next_state == RESULT);
      if (start) begin
        score       <= '0;
        max_combo   <= '0;
        hit_count   <= '0;
        miss_count  <= '0;
        wrong_count <= '0;
      end else begin
        if (hit) begin
          if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
        if (wrong_inc != 2'd0) wrong_count <= wrong_sum[8] ? 8'hFF : wrong_sum[7:0];
        if (miss && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
        if (state == PLAY && link.combo > max_combo) max_combo <= link.combo;
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed stimulus, event-level reference model checked every cycle,
// plus hand-computed expectations at the end of each scenario.
module tb_hit_judge;
  localparam int DEB   = 4;
  localparam int HIT   = 10;
  localparam int SHIFT = 3;
  localparam int S_IDLE = 0, S_PLAY = 1, S_RESULT = 2;

  logic        clk = 0, rst = 0;
  logic        red_button = 0, blue_button = 0, yellow_button = 0;
  logic [1:0]  song = 0;
  logic [15:0] score;
  logic [7:0]  max_combo, hit_count, miss_count, wrong_count;
  logic        result_valid;

  hit_judge_if bus();

  hit_judge #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .red_button(red_button), .blue_button(blue_button),
    .yellow_button(yellow_button), .song(song), .link(bus), .score(score),
    .max_combo(max_combo), .hit_count(hit_count), .miss_count(miss_count),
    .wrong_count(wrong_count), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, del_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (cycle-indexed events) ----------------
  int        m_state, m_score, m_max, m_hit, m_miss, m_wrong, cyc, last_del;
  bit        deb_now [2], deb_bef [2], note_prev [2];
  bit [15:0] rawh [2];   // bit 0 = raw level of the cycle that just ended

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // The debounced level flips once DEB consecutive synced samples disagree with it;
  // synced samples lag the raw pins by two cycles.
  function automatic bit window_all(input bit [15:0] h, input bit lvl);
    for (int j = 2; j < 2 + DEB; j++) if (h[j] != lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_score = 0; m_max = 0; m_hit = 0; m_miss = 0; m_wrong = 0;
    cyc = 0; last_del = -100;
    for (int i = 0; i < 2; i++) begin
      deb_now[i] = 0; deb_bef[i] = 0; note_prev[i] = 0; rawh[i] = '0;
    end
  endtask

  task automatic model_step();
    bit pr [2];
    bit nr, nb, hit;
    int c, cmb, nw, nxt;
    c = cyc; cmb = int'(bus.combo); nr = bus.note_R_judge; nb = bus.note_B_judge;
    for (int i = 0; i < 2; i++) pr[i] = deb_now[i] && !deb_bef[i];
    nxt = m_state;
    if (m_state == S_IDLE) begin
      if (song != 0) begin
        nxt = S_PLAY; m_score = 0; m_max = 0; m_hit = 0; m_miss = 0; m_wrong = 0;
      end
    end else if (m_state == S_PLAY) begin
      if (((note_prev[0] && !nr) || (note_prev[1] && !nb)) && last_del != c - 1)
        m_miss = min2(m_miss + 1, 255);
      if (cmb > m_max) m_max = cmb;
      if (bus.finish) nxt = S_RESULT;
      else begin
        hit = 0;
        nw  = int'(pr[0]) + int'(pr[1]);
        if (last_del != c && last_del != c - 1) begin
          if (pr[0] && nr)      begin hit = 1; nw = int'(pr[1]); end
          else if (pr[1] && nb) begin hit = 1; nw = int'(pr[0]); end
        end
        if (hit) begin
          last_del = c + 1;
          m_hit    = min2(m_hit + 1, 255);
          m_score  = min2(m_score + HIT + (cmb >> SHIFT), 65535);
        end
        m_wrong = min2(m_wrong + nw, 255);
      end
    end else if (m_state == S_RESULT) begin
      if (yellow_button) nxt = S_IDLE;
    end else nxt = S_IDLE;
    m_state = nxt;
    note_prev[0] = nr; note_prev[1] = nb;
    rawh[0] = {rawh[0][14:0], red_button};
    rawh[1] = {rawh[1][14:0], blue_button};
    for (int i = 0; i < 2; i++) begin
      deb_bef[i] = deb_now[i];
      if (window_all(rawh[i], !deb_now[i])) deb_now[i] = !deb_now[i];
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (bus.delete) del_seen++;
    check("cyc_delete", int'(bus.delete), int'(last_del == cyc));
    check("cyc_score", int'(score), m_score);
    check("cyc_max_combo", int'(max_combo), m_max);
    check("cyc_hit_count", int'(hit_count), m_hit);
    check("cyc_miss_count", int'(miss_count), m_miss);
    check("cyc_wrong_count", int'(wrong_count), m_wrong);
    check("cyc_result_valid", int'(result_valid), int'(m_state == S_RESULT));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_max"}, int'(max_combo), 0);
    check({tag, "_hit"}, int'(hit_count), 0);
    check({tag, "_miss"}, int'(miss_count), 0);
    check({tag, "_wrong"}, int'(wrong_count), 0);
    check({tag, "_rv"}, int'(result_valid), 0);
    check({tag, "_delete"}, int'(bus.delete), 0);
  endtask

  task automatic new_song();
    bus.finish = 1; cyc_wait(1); bus.finish = 0;
    check("rv_after_finish", int'(result_valid), 1);
    yellow_button = 1; cyc_wait(1); yellow_button = 0;
    check("rv_after_yellow", int'(result_valid), 0);
    song = 2'd1; cyc_wait(1); song = 2'd0;
    check("song_clears_score", int'(score), 0);
    check("song_clears_hits", int'(hit_count), 0);
  endtask

  int d0;

  initial begin
    bus.note_R_judge = 0; bus.note_B_judge = 0; bus.combo = 0; bus.finish = 0;
    #1 rst = 1;
    #2 check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 rst = 0;
    cyc_wait(1);
    song = 2'd1; cyc_wait(1); song = 2'd0;

    // Short press is filtered, long press hits once.
    d0 = del_seen;
    bus.note_R_judge = 1; red_button = 1; cyc_wait(3); red_button = 0; cyc_wait(10);
    check("short_hits", int'(hit_count), 0);
    check("short_wrong", int'(wrong_count), 0);
    check("short_deletes", del_seen - d0, 0);
    red_button = 1; cyc_wait(8); bus.note_R_judge = 0; cyc_wait(2); red_button = 0; cyc_wait(10);
    check("long_deletes", del_seen - d0, 1);
    check("long_hits", int'(hit_count), 1);
    check("long_score", int'(score), 10);
    check("long_miss", int'(miss_count), 0);

    // Red hit at combo 16; blue press lands in the lockout.
    new_song();
    d0 = del_seen;
    bus.combo = 8'd16; bus.note_R_judge = 1; bus.note_B_judge = 1;
    red_button = 1; cyc_wait(1); blue_button = 1; cyc_wait(7);
    bus.note_R_judge = 0; bus.note_B_judge = 0; cyc_wait(2);
    red_button = 0; blue_button = 0; cyc_wait(10);
    check("red_hit_score", int'(score), 12);
    check("red_hit_count", int'(hit_count), 1);
    check("lockout_wrong", int'(wrong_count), 1);
    check("lockout_deletes", del_seen - d0, 1);
    check("lockout_max", int'(max_combo), 16);

    // Wrong colour, then the unhit note scrolls away.
    bus.note_B_judge = 1; red_button = 1; cyc_wait(10); red_button = 0; cyc_wait(10);
    check("wrong_colour_wrong", int'(wrong_count), 2);
    check("wrong_colour_deletes", del_seen - d0, 1);
    bus.note_B_judge = 0; cyc_wait(2);
    check("miss_first", int'(miss_count), 1);

    // Simultaneous presses, only blue note present.
    bus.note_B_judge = 1; red_button = 1; blue_button = 1; cyc_wait(8);
    bus.note_B_judge = 0; cyc_wait(2); red_button = 0; blue_button = 0; cyc_wait(10);
    check("simul_hits", int'(hit_count), 2);
    check("simul_wrong", int'(wrong_count), 3);
    check("simul_deletes", del_seen - d0, 2);
    check("simul_score", int'(score), 24);
    check("simul_miss", int'(miss_count), 1);

    // Misses; both colours falling together count once.
    bus.note_R_judge = 1; cyc_wait(3); bus.note_R_judge = 0; cyc_wait(2);
    check("miss_red", int'(miss_count), 2);
    bus.note_R_judge = 1; bus.note_B_judge = 1; cyc_wait(3);
    bus.note_R_judge = 0; bus.note_B_judge = 0; cyc_wait(2);
    check("miss_both", int'(miss_count), 3);

    // Max combo tracking.
    bus.combo = 0;
    new_song();
    bus.combo = 8'd5; cyc_wait(1); bus.combo = 8'd9; cyc_wait(1); bus.combo = 8'd3; cyc_wait(2);
    check("max_combo_9", int'(max_combo), 9);

    // Score and hit counter saturation: 1600 hits at 41 points each.
    bus.combo = 8'd255; bus.note_R_judge = 1;
    for (int k = 0; k < 1600; k++) begin
      red_button = 1; cyc_wait(8);
      red_button = 0; bus.note_R_judge = 0; cyc_wait(1);
      bus.note_R_judge = 1; cyc_wait(5);
    end
    check("sat_score", int'(score), 65535);
    check("sat_hits", int'(hit_count), 255);
    check("sat_miss", int'(miss_count), 0);
    check("sat_max", int'(max_combo), 255);

    // finish in the same cycle as a press pulse: press ignored.
    d0 = del_seen;
    red_button = 1; cyc_wait(6); bus.finish = 1; cyc_wait(1); bus.finish = 0;
    check("finish_rv", int'(result_valid), 1);
    cyc_wait(2); red_button = 0; bus.note_R_judge = 0; cyc_wait(10);
    check("finish_deletes", del_seen - d0, 0);
    check("finish_wrong", int'(wrong_count), 0);
    check("result_hold_score", int'(score), 65535);
    check("result_hold_hits", int'(hit_count), 255);
    yellow_button = 1; cyc_wait(1); yellow_button = 0;
    check("idle_rv", int'(result_valid), 0);
    check("idle_hold_score", int'(score), 65535);
    song = 2'd1; cyc_wait(1); song = 2'd0;
    check("replay_score", int'(score), 0);
    check("replay_max", int'(max_combo), 0);
    bus.note_R_judge = 1; red_button = 1; cyc_wait(8);
    bus.note_R_judge = 0; red_button = 0; cyc_wait(10);
    check("replay_score_41", int'(score), 41);

    // Asynchronous reset mid-PLAY.
    rst = 1; #1;
    check_all_zero("midrst");
    @(posedge clk); @(posedge clk); #1 rst = 0;
    cyc_wait(1);
    d0 = del_seen;
    bus.note_R_judge = 1; red_button = 1; cyc_wait(10); red_button = 0; cyc_wait(10);
    check("post_rst_hits", int'(hit_count), 0);
    check("post_rst_wrong", int'(wrong_count), 0);
    check("post_rst_deletes", del_seen - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
